// File: rtl/apb_wdt.sv
// APB watchdog: 32-bit down-counter that flags an interrupt on first expiry and
// a sticky reset request on an unserviced second expiry; wait states on pready.
module apb_wdt #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] LOAD_RESET  = 32'hFFFF_FFFF
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        wdogint,
  output logic        wdogres
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  SETUP  = 2'd1;
  localparam logic [1:0]  ACCESS = 2'd2;

  localparam logic [2:0]  WS         = 3'(WAIT_STATES);
  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  localparam logic [8:0]  A_LOAD   = 9'h000;
  localparam logic [8:0]  A_VALUE  = 9'h001;
  localparam logic [8:0]  A_CTRL   = 9'h002;
  localparam logic [8:0]  A_INTCLR = 9'h003;
  localparam logic [8:0]  A_RIS    = 9'h004;
  localparam logic [8:0]  A_MIS    = 9'h005;
  localparam logic [8:0]  A_LOCK   = 9'h010;

  logic [1:0]  state_q, state_nx, cur_state;
  logic [2:0]  wait_q, wait_nx;
  logic [31:0] load_q, load_nx;
  logic [31:0] count_q, count_nx;
  logic        inten_q, inten_nx;
  logic        resen_q, resen_nx;
  logic        ris_q, ris_nx;
  logic        res_req_q, res_req_nx;
  logic        locked_q, locked_nx;
  logic [31:0] prdata_q, rdata_nx;

  logic [8:0]  word_addr;
  logic        commit, wr;
  logic        wr_load, wr_ctrl, wr_intclr, wr_lock;
  logic        stop_cnt, expiry;
  logic        unused_addr_bits;

  assign word_addr        = paddr[10:2];
  assign unused_addr_bits = ^{paddr[31:11], paddr[1:0]};

  // A setup phase on the bus always means SETUP, whatever the registered state,
  // so back-to-back transfers need no extra idle cycle.
  assign cur_state = (psel && !penable) ? SETUP : state_q;
  assign pready    = (cur_state != ACCESS) || (wait_q >= WS);
  assign commit    = (cur_state == ACCESS) && psel && penable && pready;
  assign wr        = commit && pwrite;

  assign wr_load   = wr && !locked_q && (word_addr == A_LOAD);
  assign wr_ctrl   = wr && !locked_q && (word_addr == A_CTRL);
  assign wr_intclr = wr && !locked_q && (word_addr == A_INTCLR);
  assign wr_lock   = wr && (word_addr == A_LOCK);

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path through the case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = IDLE;
    wait_nx  = wait_q;
    case (cur_state)
      SETUP: begin
        state_nx = ACCESS;
        wait_nx  = '0;
      end
      ACCESS: begin
        if (psel && penable && !pready) begin
          state_nx = ACCESS;
          wait_nx  = wait_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // A CTRL write clearing INTEN freezes the counter in the same cycle and
  // swallows any expiry that would have happened there.
  assign stop_cnt = wr_ctrl && !pwdata[0];
  assign expiry   = inten_q && (count_q == '0) && !stop_cnt;

  always_comb begin
    load_nx    = wr_load ? pwdata : load_q;
    inten_nx   = wr_ctrl ? pwdata[0] : inten_q;
    resen_nx   = wr_ctrl ? pwdata[1] : resen_q;
    locked_nx  = wr_lock ? (pwdata != UNLOCK_KEY) : locked_q;
    ris_nx     = wr_intclr ? 1'b0 : (ris_q | expiry);
    res_req_nx = res_req_q | (expiry && ris_q && resen_q && !wr_intclr);

    count_nx = count_q;
    if (wr_load) begin
      count_nx = pwdata;
    end else if (wr_intclr || (wr_ctrl && pwdata[0] && !inten_q)) begin
      count_nx = load_q;
    end else if (inten_q && !stop_cnt) begin
      count_nx = (count_q == '0) ? load_q : count_q - 32'd1;
    end
  end

  // Read data is captured from next-state values so the word presented in the
  // pready cycle matches register contents during that cycle.
  always_comb begin
    rdata_nx = '0;
    case (word_addr)
      A_LOAD:  rdata_nx = load_nx;
      A_VALUE: rdata_nx = count_nx;
      A_CTRL:  rdata_nx = {30'd0, resen_nx, inten_nx};
      A_RIS:   rdata_nx = {31'd0, ris_nx};
      A_MIS:   rdata_nx = {31'd0, ris_nx & inten_nx};
      A_LOCK:  rdata_nx = {31'd0, locked_nx};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      load_q    <= LOAD_RESET;
      count_q   <= LOAD_RESET;
      inten_q   <= 1'b0;
      resen_q   <= 1'b0;
      ris_q     <= 1'b0;
      res_req_q <= 1'b0;
      locked_q  <= 1'b0;
      prdata_q  <= '0;
      wdogint   <= 1'b0;
      wdogres   <= 1'b0;
    end else begin
      state_q   <= state_nx;
      wait_q    <= wait_nx;
      load_q    <= load_nx;
      count_q   <= count_nx;
      inten_q   <= inten_nx;
      resen_q   <= resen_nx;
      ris_q     <= ris_nx;
      res_req_q <= res_req_nx;
      locked_q  <= locked_nx;
      prdata_q  <= (state_nx == ACCESS && !pwrite) ? rdata_nx : '0;
      wdogint   <= ris_q & inten_q;
      wdogres   <= res_req_q;
    end
  end

  assign prdata = (cur_state == ACCESS && pready) ? prdata_q : '0;

endmodule

// File: tb/tb_apb_wdt.sv
// Self-checking bench for apb_wdt: directed scenarios plus randomized APB
// traffic scored against a behavioural model of the watchdog register set.
module tb_apb_wdt;

  localparam int unsigned WS  = 1;
  localparam logic [31:0] KEY = 32'h1ACC_E551;

  logic        pclk = 1'b0;
  logic        preset, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, wdogint, wdogres;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  apb_wdt #(.WAIT_STATES(WS), .LOAD_RESET(32'hFFFF_FFFF)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .wdogint (wdogint),
    .wdogres (wdogres)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Behavioural model: register contents during the current cycle.
  logic [31:0] m_load = 32'hFFFF_FFFF, m_count = 32'hFFFF_FFFF;
  bit          m_inten, m_resen, m_ris, m_res_req, m_locked, m_int, m_res;
  // Transfer committing at the coming edge, posted by the APB task.
  bit          c_valid = 1'b0, c_wr;
  int          c_idx;
  logic [31:0] c_data;

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0:       return m_load;
      1:       return m_count;
      2:       return {30'd0, m_resen, m_inten};
      4:       return {31'd0, m_ris};
      5:       return {31'd0, m_ris & m_inten};
      16:      return {31'd0, m_locked};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge pclk) begin : model
    int idx;
    bit stop, exp;
    if (preset) begin
      m_load = 32'hFFFF_FFFF; m_count = 32'hFFFF_FFFF;
      m_inten = 0; m_resen = 0; m_ris = 0; m_res_req = 0;
      m_locked = 0; m_int = 0; m_res = 0;
    end else begin
      idx = (c_valid && c_wr) ? c_idx : -1;
      if (m_locked && (idx inside {0, 2, 3})) idx = -1;
      m_int = m_ris && m_inten;
      m_res = m_res_req;
      stop  = (idx == 2) && !c_data[0];
      exp   = m_inten && (m_count == 0) && !stop;
      if (m_inten && !stop) m_count = (m_count == 0) ? m_load : m_count - 1;
      if (exp && idx != 3) begin
        if (!m_ris) m_ris = 1;
        else if (m_resen) m_res_req = 1;
      end
      case (idx)
        0:  begin m_load = c_data; m_count = c_data; end
        2:  begin
              if (c_data[0] && !m_inten) m_count = m_load;
              m_inten = c_data[0];
              m_resen = c_data[1];
            end
        3:  begin m_ris = 0; m_count = m_load; end
        16: m_locked = (c_data != KEY);
        default: ;
      endcase
    end
  end

  always @(negedge pclk) begin
    if (mon_en) begin
      check("wdogint", 32'(wdogint), 32'(m_int));
      check("wdogres", 32'(wdogres), 32'(m_res));
      if (!psel) check("prdata_idle", prdata, 32'd0);
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input string tag, output logic [31:0] rdata);
    int waits;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1 penable = 1;
    waits = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && waits < 16) begin
      waits++;
      @(negedge pclk);
    end
    check({tag, "_wait"}, 32'(waits), 32'(WS));
    rdata = prdata;
    if (!wr) check(tag, prdata, m_read(int'(addr[10:2])));
    c_valid = 1; c_wr = wr; c_idx = int'(addr[10:2]); c_data = data;
    @(posedge pclk); #1;
    c_valid = 0; psel = 0; penable = 0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge pclk);
      #1;
    end
  endtask

  task automatic do_reset();
    preset = 1; psel = 0; penable = 0; c_valid = 0;
    @(posedge pclk); #1 preset = 0;
  endtask

  logic [31:0] rst_addr [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h40};
  logic [31:0] rst_val  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};

  initial begin
    logic [31:0] r, a, d;
    bit wr;
    int cyc, sel;

    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; preset = 1;
    @(posedge pclk); #1 preset = 0; mon_en = 1;

    // Reset state of outputs and every register.
    @(negedge pclk);
    check("rst_pready", 32'(pready), 32'd1);
    check("rst_prdata", prdata, 32'd0);
    check("rst_wdogint", 32'(wdogint), 32'd0);
    @(posedge pclk); #1;
    for (int i = 0; i < 7; i++) begin
      apb(0, rst_addr[i], 0, "rst_read", r);
      check("rst_const", r, rst_val[i]);
    end

    // LOAD=10, enable: interrupt 12 cycles after the CTRL commit, then clear.
    apb(1, 32'h00, 32'd10, "t2_load", r);
    apb(1, 32'h08, 32'd1, "t2_ctrl", r);
    cyc = 0;
    @(negedge pclk);
    while (!wdogint && cyc < 40) begin @(posedge pclk); cyc++; @(negedge pclk); end
    check("t2_int_latency", 32'(cyc), 32'd12);
    @(posedge pclk); #1;
    apb(0, 32'h04, 0, "t2_value_a", r);
    apb(0, 32'h04, 0, "t2_value_b", r);
    apb(0, 32'h14, 0, "t2_mis", r);
    apb(1, 32'h0C, 32'd0, "t2_intclr", r);
    @(negedge pclk); @(negedge pclk);
    check("t2_int_fall", 32'(wdogint), 32'd0);
    @(posedge pclk); #1;

    // LOAD=5, INTEN+RESEN, never serviced: reset request 6 cycles after interrupt.
    do_reset();
    apb(1, 32'h00, 32'd5, "t3_load", r);
    apb(1, 32'h08, 32'd3, "t3_ctrl", r);
    cyc = 0;
    @(negedge pclk);
    while (!wdogint && cyc < 40) begin @(posedge pclk); cyc++; @(negedge pclk); end
    check("t3_int_latency", 32'(cyc), 32'd7);
    cyc = 0;
    while (!wdogres && cyc < 40) begin @(posedge pclk); cyc++; @(negedge pclk); end
    check("t3_res_gap", 32'(cyc), 32'd6);
    @(posedge pclk); #1;
    apb(1, 32'h0C, 32'd0, "t3_intclr", r);
    idle(20);
    @(negedge pclk);
    check("t3_res_sticky", 32'(wdogres), 32'd1);
    @(posedge pclk); #1;
    do_reset();
    @(negedge pclk);
    check("t3_res_cleared", 32'(wdogres), 32'd0);
    @(posedge pclk); #1;

    // Lock blocks LOAD writes; the key unlocks.
    apb(1, 32'h40, 32'd0, "t4_lock", r);
    apb(1, 32'h00, 32'd3, "t4_load_locked", r);
    apb(0, 32'h00, 0, "t4_rd_locked", r);
    check("t4_load_kept", r, 32'hFFFF_FFFF);
    apb(0, 32'h40, 0, "t4_rd_lock", r);
    check("t4_lock_flag", r, 32'd1);
    apb(1, 32'h40, KEY, "t4_unlock", r);
    apb(1, 32'h00, 32'd3, "t4_load_open", r);
    apb(0, 32'h00, 0, "t4_rd_open", r);
    check("t4_load_new", r, 32'd3);

    // INTCLR commit on the second expiry edge (RIS=1, RESEN=1): the clear wins.
    do_reset();
    apb(1, 32'h00, 32'd9, "t5_load", r);
    apb(1, 32'h08, 32'd3, "t5_ctrl", r);
    idle(17);
    apb(1, 32'h0C, 32'd0, "t5_intclr", r);
    apb(0, 32'h10, 0, "t5_ris", r);
    check("t5_ris_clear", r, 32'd0);
    apb(0, 32'h04, 0, "t5_value", r);
    @(negedge pclk);
    check("t5_no_res", 32'(wdogres), 32'd0);
    @(posedge pclk); #1;

    // Back-to-back write/read to an unmapped offset.
    apb(1, 32'h7FC, 32'hDEAD_BEEF, "t6_wr_hole", r);
    apb(0, 32'h7FC, 0, "t6_rd_hole", r);
    check("t6_hole_zero", r, 32'd0);
    @(negedge pclk);
    check("t6_idle_pready", 32'(pready), 32'd1);
    @(posedge pclk); #1;
    apb(0, 32'h00, 0, "t6_rd_load", r);
    check("t6_load_same", r, 32'd9);

    // Reset asserted in the ready cycle of a LOAD write aborts it.
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h00; pwdata = 32'h55;
    @(posedge pclk); #1 penable = 1;
    cyc = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && cyc < 16) begin cyc++; @(negedge pclk); end
    preset = 1;
    @(posedge pclk); #1;
    preset = 0; psel = 0; penable = 0;
    @(negedge pclk);
    check("t7_abort_pready", 32'(pready), 32'd1);
    @(posedge pclk); #1;
    apb(0, 32'h00, 0, "t7_rd_load", r);
    check("t7_load_reset", r, 32'hFFFF_FFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: a = 32'h00;
        1: a = 32'h04;
        2: a = 32'h08;
        3: a = 32'h0C;
        4: a = 32'h10;
        5: a = 32'h14;
        6: a = 32'h40;
        default: a = 32'($urandom_range(0, 511)) << 2;
      endcase
      wr = 1'($urandom_range(0, 1));
      case (a)
        32'h00:  d = 32'($urandom_range(0, 20));
        32'h08:  d = 32'($urandom_range(0, 3));
        32'h40:  d = ($urandom_range(0, 4) != 0) ? KEY : $urandom;
        default: d = $urandom;
      endcase
      apb(wr, a, d, "rnd", r);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
